// File: rtl/piso_shift_register.sv
// -----------------------------------------------------------------------------
// piso_shift_register
//
// Parallel-in serial-out transmit register. A WIDTH-bit word is accepted with a
// ready/load handshake and then shifted out one bit per clock. If load is held
// high, the next word can be accepted in the same cycle that the last bit of
// the current word is shown. Consecutive words then go out with no gap.
//
// Parameters
//   WIDTH      word width in bits (>= 2)
//   MSB_FIRST  1: bit WIDTH-1 goes out first; 0: bit 0 goes out first
//
// Ports
//   clk           rising-edge clock, sole clock domain
//   reset         asynchronous active-low reset (0 = reset)
//   data_in       parallel word, sampled only when a load is accepted
//   load          load request, qualified by ready
//   ready         block can accept a word this cycle (combinational)
//   serial_out    current serial bit (0 while idle)
//   serial_valid  serial_out carries a valid bit
//   done          one-cycle pulse while the last bit of a word is on serial_out
// -----------------------------------------------------------------------------
module piso_shift_register #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load,
  output logic             ready,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             done
);

  localparam int unsigned    CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    count_q, count_d;

  logic at_last;
  logic accept;

  // The last bit of a word is on the line. A new word may be accepted now.
  assign at_last = (state_q == SHIFT) && (count_q == LAST);
  assign ready   = (state_q == IDLE) || at_last;
  assign accept  = load && ready;

  // NOTE: every variable driven here gets a default first. Without that, a
  // path that does not assign it would infer a latch. The combinational block
  // uses blocking '=' assignments. The clocked block below uses only '<='.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    count_d = count_q;

    if (accept) begin
      shreg_d = data_in;
      count_d = '0;
      state_d = SHIFT;
    end else if (state_q == SHIFT) begin
      if (MSB_FIRST) begin
        shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
      end else begin
        shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
      end
      if (at_last) begin
        // Return to idle with a clean count. For a WIDTH that is not a power
        // of two, the count does not wrap to 0 by itself.
        count_d = '0;
        state_d = IDLE;
      end else begin
        count_d = count_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      count_q <= count_d;
    end
  end

  // Outputs are decoded only from registered state. serial_out is gated in
  // IDLE, so leftover or unknown register contents never reach the line.
  assign serial_valid = (state_q == SHIFT);
  assign done         = at_last;
  assign serial_out   = serial_valid &&
                        (MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0]);

endmodule

// File: tb/tb_piso_shift_register.sv
// -----------------------------------------------------------------------------
// tb_piso_shift_register
//
// Drives two instances of piso_shift_register with the same stimulus. One is
// built MSB-first and the other LSB-first. Each instance is compared every
// cycle against a queue model of the serial line. When a word is accepted,
// its bits are appended to the queue in transmit order. The head of the queue
// is the bit currently on the line. The head is popped on every clock edge.
// -----------------------------------------------------------------------------
module tb_piso_shift_register;

  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] data_in;
  logic             load;

  logic ready_m, serial_out_m, serial_valid_m, done_m;
  logic ready_l, serial_out_l, serial_valid_l, done_l;

  always #5 clk = ~clk;

  piso_shift_register #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) u_dut_msb (
    .clk          (clk),
    .reset        (reset),
    .data_in      (data_in),
    .load         (load),
    .ready        (ready_m),
    .serial_out   (serial_out_m),
    .serial_valid (serial_valid_m),
    .done         (done_m)
  );

  piso_shift_register #(.WIDTH(WIDTH), .MSB_FIRST(1'b0)) u_dut_lsb (
    .clk          (clk),
    .reset        (reset),
    .data_in      (data_in),
    .load         (load),
    .ready        (ready_l),
    .serial_out   (serial_out_l),
    .serial_valid (serial_valid_l),
    .done         (done_l)
  );

  // Expected serial line contents. The head is the bit shown this cycle.
  bit q_msb[$];
  bit q_lsb[$];

  int pass_cnt = 0;
  int total    = 0;

  task automatic check(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed=%b expected=%b (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic check_line(input string who, input bit q[$], input logic so,
                            input logic sv, input logic dn, input logic rd);
    logic e_valid, e_out, e_done, e_ready;
    e_valid = (q.size() > 0);
    e_out   = (q.size() > 0) ? q[0] : 1'b0;
    e_done  = (q.size() == 1);
    e_ready = (q.size() <= 1);
    check({who, ".serial_out"},   so, e_out);
    check({who, ".serial_valid"}, sv, e_valid);
    check({who, ".done"},         dn, e_done);
    check({who, ".ready"},        rd, e_ready);
  endtask

  task automatic check_all();
    check_line("msb", q_msb, serial_out_m, serial_valid_m, done_m, ready_m);
    check_line("lsb", q_lsb, serial_out_l, serial_valid_l, done_l, ready_l);
  endtask

  // One clock edge of the line model. Acceptance uses the ready value from
  // before the edge.
  task automatic model_edge(input logic ld, input logic [WIDTH-1:0] d);
    bit acc;
    acc = ld && (q_msb.size() <= 1);
    if (q_msb.size() > 0) void'(q_msb.pop_front());
    if (q_lsb.size() > 0) void'(q_lsb.pop_front());
    if (acc) begin
      for (int i = 0; i < WIDTH; i++) begin
        q_msb.push_back(d[WIDTH-1-i]);
        q_lsb.push_back(d[i]);
      end
    end
  endtask

  // Apply inputs for one cycle. The checks run on the falling edge.
  task automatic cycle(input logic ld, input logic [WIDTH-1:0] d);
    load    = ld;
    data_in = d;
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_edge(ld, d);
    #1;
  endtask

  task automatic async_reset_pulse();
    reset = 1'b0;
    #1;
    q_msb.delete();
    q_lsb.delete();
    check_all();            // outputs must settle before any clock edge
    @(posedge clk);
    #1;
    check_all();
    reset = 1'b1;
    #1;
  endtask

  initial begin
    reset   = 1'b0;
    load    = 1'b0;
    data_in = '0;
    #2;
    check_all();            // reset values, no clock edge yet
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;

    // Single word 8'hA5, then idle with unknown data_in and load low.
    cycle(1'b1, 8'hA5);
    for (int i = 0; i < WIDTH + 2; i++) cycle(1'b0, 'x);

    // Single word 8'h01.
    cycle(1'b1, 8'h01);
    for (int i = 0; i < WIDTH + 1; i++) cycle(1'b0, '0);

    // Back-to-back: load held, 8'hFF then 8'h00.
    cycle(1'b1, 8'hFF);
    for (int i = 0; i < WIDTH - 1; i++) cycle(1'b1, 8'h00);
    cycle(1'b1, 8'h00);
    for (int i = 0; i < WIDTH - 1; i++) cycle(1'b0, 8'h00);
    cycle(1'b0, 8'h00);

    // Ignored load pulse at count 3 of 8'hC3.
    cycle(1'b1, 8'hC3);
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00);
    cycle(1'b1, 8'h3C);
    for (int i = 0; i < WIDTH; i++) cycle(1'b0, 8'h00);

    // Reset at count 4 of 8'hF0, then a clean 8'h81.
    cycle(1'b1, 8'hF0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00);
    @(negedge clk);
    #2;
    async_reset_pulse();
    cycle(1'b0, 8'h00);
    cycle(1'b1, 8'h81);
    for (int i = 0; i < WIDTH + 1; i++) cycle(1'b0, 8'h00);

    // Randomized traffic with occasional loads during shifting.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 2) != 0), WIDTH'($urandom));
    end
    // Random mid-word reset, then more traffic.
    cycle(1'b1, WIDTH'($urandom));
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00);
    async_reset_pulse();
    for (int i = 0; i < 200; i++) begin
      cycle(($urandom_range(0, 3) == 0), WIDTH'($urandom));
    end
    for (int i = 0; i < WIDTH + 2; i++) cycle(1'b0, 8'h00);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
